additionneur_8bit_sync: RTL and testbench



---
 rtl/additionneur_pkg.sv | 15 +
 rtl/full_adder_1bit.sv | 21 ++
 rtl/additionneur_8bit_sync.sv | 104 ++++++++++
 tb/tb_additionneur_8bit_sync.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/additionneur_pkg.sv
// ---------------------------------------------------------------------------
// additionneur_pkg
// Shared constants and types for the registered ripple-carry adder.
//   ADD_WIDTH_DEF  : default operand/sum width in bits
//   add_word_t     : operand / sum word at the default width
//   add_result_t   : exact result word {carry, sum} at the default width
// ---------------------------------------------------------------------------
package additionneur_pkg;

  localparam int ADD_WIDTH_DEF = 8;

  typedef logic [ADD_WIDTH_DEF-1:0] add_word_t;
  typedef logic [ADD_WIDTH_DEF:0]   add_result_t;

endpackage : additionneur_pkg

// File: rtl/full_adder_1bit.sv
// ---------------------------------------------------------------------------
// full_adder_1bit
// One cell of the ripple-carry chain.
//   a, b  : operand bits
//   cin   : carry from the previous (less significant) cell
//   s     : sum bit
//   cout  : carry into the next (more significant) cell
// ---------------------------------------------------------------------------
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Majority function gives the carry; the three-way XOR gives the sum.
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1bit

// File: rtl/additionneur_8bit_sync.sv
// ---------------------------------------------------------------------------
// additionneur_8bit_sync
// Registered WIDTH-bit ripple-carry adder: {rout, s} <= a + b + rin, one
// cycle after in_valid, with out_valid marking the cycle the result lands.
//   clk       : system clock, rising edge
//   rst_n     : synchronous active-low reset
//   in_valid  : a, b, rin carry a new operation this cycle
//   a, b      : unsigned operands
//   rin       : carry-in
//   s         : registered sum (low WIDTH bits)
//   rout      : registered carry-out (bit WIDTH)
//   ovf       : registered signed overflow (only with ADDITIONNEUR_OVF_FLAG_EN)
//   out_valid : s/rout were updated by the previous cycle's in_valid
// Optional build macro: ADDITIONNEUR_OVF_FLAG_EN adds the ovf output.
// ---------------------------------------------------------------------------
module additionneur_8bit_sync
  import additionneur_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rin,
  output logic [WIDTH-1:0] s,
  output logic             rout,
`ifdef ADDITIONNEUR_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sumBits;

  logic [WIDTH-1:0] sum_d,   sum_q;
  logic             carry_d, carry_q;
  logic             valid_q;

  // carry[i] feeds cell i; carry[WIDTH] is the carry-out of the chain.
  assign carry[0] = rin;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_chain
    full_adder_1bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sumBits[i]),
      .cout (carry[i+1])
    );
  end

  // Operands are only looked at under in_valid, so unknown idle operands
  // never reach the result registers.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (in_valid) begin
      sum_d   = sumBits;
      carry_d = carry[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      valid_q <= in_valid;
    end
  end

  assign s         = sum_q;
  assign rout      = carry_q;
  assign out_valid = valid_q;

`ifdef ADDITIONNEUR_OVF_FLAG_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carries into and out of the sign bit disagree.
  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule : additionneur_8bit_sync

// File: tb/tb_additionneur_8bit_sync.sv
// ---------------------------------------------------------------------------
// tb_additionneur_8bit_sync
// Directed vectors with hand-computed results; a queue carries expected
// results from the stimulus side to an independent output monitor.
// Define ADDITIONNEUR_OVF_FLAG_EN to exercise the ovf output as well.
// ---------------------------------------------------------------------------
module tb_additionneur_8bit_sync;
  import additionneur_pkg::*;

  typedef struct {
    add_word_t s;
    logic      rout;
    logic      ovf;
    int        issue;
  } expect_t;

  logic      clk;
  logic      rst_n;
  logic      in_valid;
  add_word_t a;
  add_word_t b;
  logic      rin;
  add_word_t s;
  logic      rout;
  logic      out_valid;
`ifdef ADDITIONNEUR_OVF_FLAG_EN
  logic      ovf;
`endif

  expect_t expQ[$];
  int      nVectors = 0;
  int      nMiscompares = 0;
  int      cycle = 0;

  additionneur_8bit_sync #(.WIDTH(ADD_WIDTH_DEF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .rin       (rin),
    .s         (s),
    .rout      (rout),
`ifdef ADDITIONNEUR_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .out_valid (out_valid)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to verify the one-cycle latency of each result.
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: whenever the DUT presents a result, pop and compare it.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      expect_t e;
      logic    ovfAct;
      nVectors++;
      if (expQ.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL unexpectedResult: got s=%h rout=%b with nothing expected", s, rout);
      end else begin
        e = expQ.pop_front();
`ifdef ADDITIONNEUR_OVF_FLAG_EN
        ovfAct = ovf;
`else
        ovfAct = e.ovf;
`endif
        if (s !== e.s || rout !== e.rout || ovfAct !== e.ovf || cycle != e.issue + 1) begin
          nMiscompares++;
          $display("[TB] FAIL result: got s=%h rout=%b ovf=%b at cycle %0d, expected s=%h rout=%b ovf=%b at cycle %0d",
                   s, rout, ovfAct, cycle, e.s, e.rout, e.ovf, e.issue + 1);
        end
      end
    end
  end

  // Drive one cycle of inputs; a valid operation outside reset queues its
  // hand-computed result for the monitor.
  task automatic applyStimulus(input logic v, input add_word_t av, input add_word_t bv,
                               input logic rv, input add_word_t expS, input logic expRout,
                               input logic expOvf);
    expect_t e;
    in_valid = v;
    a        = av;
    b        = bv;
    rin      = rv;
    if (v && rst_n) begin
      e.s     = expS;
      e.rout  = expRout;
      e.ovf   = expOvf;
      e.issue = cycle;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Direct check of the output state outside the scoreboard flow.
  task automatic checkOutput(input string name, input logic expValid, input add_word_t expS,
                             input logic expRout, input logic expOvf);
    logic ovfAct;
`ifdef ADDITIONNEUR_OVF_FLAG_EN
    ovfAct = ovf;
`else
    ovfAct = expOvf;
`endif
    nVectors++;
    if (out_valid !== expValid || s !== expS || rout !== expRout || ovfAct !== expOvf) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got out_valid=%b s=%h rout=%b ovf=%b, expected out_valid=%b s=%h rout=%b ovf=%b",
               name, out_valid, s, rout, ovfAct, expValid, expS, expRout, expOvf);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    rin      = 1'b0;

    // Reset must win over an active in_valid.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
      checkOutput("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);  // zero
    applyStimulus(1'b1, 8'd201, 8'd12, 1'b0, 8'd213, 1'b0, 1'b0); // no carry
    applyStimulus(1'b1, 8'd201, 8'd75, 1'b0, 8'd20, 1'b1, 1'b0);  // 276

    // Idle with unknown operands: result holds, out_valid drops.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 'x, 'x, 1'bx, 8'h00, 1'b0, 1'b0);
      checkOutput("hold", 1'b0, 8'd20, 1'b1, 1'b0);
    end

    // Back-to-back stream including wrap-around and signed overflow cases.
    applyStimulus(1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    checkOutput("streamLast", 1'b1, 8'h4B, 1'b0, 1'b0);

    // Reset while a result is showing and another operation is offered.
    rst_n = 1'b0;
    applyStimulus(1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midReset", 1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("afterReset", 1'b0, 8'h02, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Every queued result must have been observed.
    nVectors++;
    if (expQ.size() != 0) begin
      nMiscompares++;
      $display("[TB] FAIL pending: %0d results never appeared, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule : tb_additionneur_8bit_sync
